risc_toy_dmem: RTL and testbench

- Data-memory responder at the far end of the RISC_TOY data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Single-ported word memory with a post-reset zero-fill sequence, one-cycle registered read data, a sticky out-of-range error flag and saturating access counters.
- Instantiated next to the core in the test/system top.

---
 rtl/risc_toy_dmem.sv | 198 +++++++++++++++++++
 tb/tb_risc_toy_dmem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_dmem.sv
// risc_toy_dmem: data-memory responder for the RISC_TOY data port.
//
// After every reset the memory is zero-filled, one word per cycle. Once the
// fill is done, reads return registered data one cycle after the request.
// Out-of-range accesses raise a sticky error flag. Two saturating counters
// count the accepted in-range reads and writes.
//
// Parameters:
//   AW     word-address width of the storage (DEPTH = 2**AW words)
//   CNT_W  width of RD_CNT / WR_CNT
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   DREQ/DRW            request strobe, 1 = write / 0 = read
//   DADDR/DWDATA        word address, write data
//   DRDATA              registered read data
//   BUSY                high while the zero-fill is running
//   ADDR_ERR, ERR_CLR   sticky out-of-range flag and its clear
//   RD_CNT, WR_CNT      saturating access counters
//
// Optional feature (macro RISC_TOY_DMEM_PARITY_EN):
//   Each word stores an extra even-parity bit. The macro adds input PAR_INJ,
//   which inverts the stored parity bit on a write, and the sticky output
//   PAR_ERR, which is set when a read finds a parity mismatch.

module risc_toy_dmem #(
    parameter int AW    = 10,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DREQ,
    input  logic             DRW,
    input  logic [29:0]      DADDR,
    input  logic [31:0]      DWDATA,
    output logic [31:0]      DRDATA,
    output logic             BUSY,
    output logic             ADDR_ERR,
    input  logic             ERR_CLR,
    output logic [CNT_W-1:0] RD_CNT,
    output logic [CNT_W-1:0] WR_CNT
`ifdef RISC_TOY_DMEM_PARITY_EN
    ,
    input  logic             PAR_INJ,
    output logic             PAR_ERR
`endif
);

    localparam int DEPTH = 2 ** AW;
`ifdef RISC_TOY_DMEM_PARITY_EN
    localparam int MW = 33;    // bit 32 holds the stored parity
`else
    localparam int MW = 32;
`endif

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [31:0]       drdata_q, drdata_d;
    logic              addr_err_q, addr_err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
`ifdef RISC_TOY_DMEM_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    logic [MW-1:0]     mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [MW-1:0]     mem_wdata;

    logic              in_range;
    logic [AW-1:0]     index;
    logic [MW-1:0]     rd_word;

    assign in_range = (DADDR[29:AW] == '0);
    assign index    = DADDR[AW-1:0];
    assign rd_word  = mem[index];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: the fill walks idx up and leaves CLEAR on the edge
    // that writes the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(DEPTH - 1)) state_d = S_READY;
            end
            S_READY: state_d = S_READY;
            default: state_d = S_CLEAR;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state_q == S_CLEAR);
    end

    // Datapath: memory port, read data, error flag, counters
    always_comb begin
        logic err_set;
`ifdef RISC_TOY_DMEM_PARITY_EN
        logic par_set;
        par_set   = 1'b0;
`endif
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = '0;
        drdata_d  = drdata_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;

        if (state_q == S_CLEAR) begin
            // Zero-fill owns the port; requests are ignored.
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = '0;
        end else if (DREQ) begin
            if (in_range) begin
                if (DRW) begin
                    mem_we    = 1'b1;
                    mem_waddr = index;
`ifdef RISC_TOY_DMEM_PARITY_EN
                    mem_wdata = {(^DWDATA) ^ PAR_INJ, DWDATA};
`else
                    mem_wdata = DWDATA;
`endif
                    if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end else begin
                    drdata_d = rd_word[31:0];
                    if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
`ifdef RISC_TOY_DMEM_PARITY_EN
                    par_set = ((^rd_word[31:0]) != rd_word[32]);
`endif
                end
            end else begin
                // Out-of-range writes are dropped; reads return zero.
                err_set = 1'b1;
                if (!DRW) drdata_d = '0;
            end
        end

        // A new error wins over a clear in the same cycle.
        addr_err_d = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : addr_err_q);
`ifdef RISC_TOY_DMEM_PARITY_EN
        par_err_d  = par_set ? 1'b1 : (ERR_CLR ? 1'b0 : par_err_q);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drdata_q   <= '0;
            addr_err_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
`ifdef RISC_TOY_DMEM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            drdata_q   <= drdata_d;
            addr_err_q <= addr_err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
`ifdef RISC_TOY_DMEM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Storage has no reset. The fill that follows every reset re-zeroes it,
    // and the reset cycle itself never writes.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign DRDATA   = drdata_q;
    assign ADDR_ERR = addr_err_q;
    assign RD_CNT   = rd_cnt_q;
    assign WR_CNT   = wr_cnt_q;
`ifdef RISC_TOY_DMEM_PARITY_EN
    assign PAR_ERR  = par_err_q;
`endif

endmodule

// File: tb/tb_risc_toy_dmem.sv
// Testbench for risc_toy_dmem (AW=4, CNT_W=4).
module tb_risc_toy_dmem;
    localparam int AW    = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             CLK = 1'b0;
    logic             RST, DREQ, DRW, ERR_CLR;
    logic [29:0]      DADDR;
    logic [31:0]      DWDATA, DRDATA;
    logic             BUSY, ADDR_ERR;
    logic [CNT_W-1:0] RD_CNT, WR_CNT;
`ifdef RISC_TOY_DMEM_PARITY_EN
    logic             PAR_INJ, PAR_ERR;
`endif

    risc_toy_dmem #(.AW(AW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .BUSY(BUSY), .ADDR_ERR(ADDR_ERR),
        .ERR_CLR(ERR_CLR), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
`ifdef RISC_TOY_DMEM_PARITY_EN
        , .PAR_INJ(PAR_INJ), .PAR_ERR(PAR_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [12];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] sb_q [$];
    int          m_rd = 0;
    int          m_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One request cycle; the expected DRDATA goes into the scoreboard and is
    // compared after the edge that produces it.
    task automatic do_req(input logic rw, input logic [29:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input string name);
        logic [31:0] e;
        sb_q.push_back(exp_rd);
        DREQ = 1'b1; DRW = rw; DADDR = a; DWDATA = wd;
        step();
        DREQ = 1'b0; DRW = 1'b0;
        if (a[29:AW] == '0) begin
            if (rw) begin if (m_wr < CMAX) m_wr++; end
            else    begin if (m_rd < CMAX) m_rd++; end
        end
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(name, DRDATA, e);
        end
    endtask

    // Counts cycles until BUSY falls, while hammering the port with requests
    // that must be ignored.
    task automatic fill_wait(input string name);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < 40) begin
            DREQ = 1'b1; DRW = n[0] ? 1'b0 : 1'b1;
            DADDR = n[0] ? 30'h400 : 30'h0; DWDATA = 32'hDEADBEEF;
            step();
            n++;
        end
        DREQ = 1'b0; DRW = 1'b0;
        check(name, 32'(n), 32'd16);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 32'd1);
        check({tag, "_drdata"}, DRDATA, 32'd0);
        check({tag, "_addr_err"}, 32'(ADDR_ERR), 32'd0);
        check({tag, "_rd_cnt"}, 32'(RD_CNT), 32'd0);
        check({tag, "_wr_cnt"}, 32'(WR_CNT), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 30'd5,  32'h0,        32'h0};
        tbl[1]  = '{1'b0, 30'd0,  32'h0,        32'h0};
        tbl[2]  = '{1'b1, 30'd3,  32'hCAFEF00D, 32'h0};
        tbl[3]  = '{1'b0, 30'd3,  32'h0,        32'hCAFEF00D};
        tbl[4]  = '{1'b1, 30'd7,  32'h12345678, 32'hCAFEF00D};
        tbl[5]  = '{1'b0, 30'd7,  32'h0,        32'h12345678};
        tbl[6]  = '{1'b1, 30'd15, 32'hFFFFFFFF, 32'h12345678};
        tbl[7]  = '{1'b0, 30'd15, 32'h0,        32'hFFFFFFFF};
        tbl[8]  = '{1'b0, 30'd3,  32'h0,        32'hCAFEF00D};
        tbl[9]  = '{1'b1, 30'd3,  32'h0,        32'hCAFEF00D};
        tbl[10] = '{1'b0, 30'd3,  32'h0,        32'h0};
        tbl[11] = '{1'b0, 30'd15, 32'h0,        32'hFFFFFFFF};

        RST = 1'b1; DREQ = 1'b0; DRW = 1'b0; ERR_CLR = 1'b0; DADDR = '0; DWDATA = '0;
`ifdef RISC_TOY_DMEM_PARITY_EN
        PAR_INJ = 1'b0;
`endif
        step(); step();
        check_reset_state("rst");
`ifdef RISC_TOY_DMEM_PARITY_EN
        check("rst_par_err", 32'(PAR_ERR), 32'd0);
`endif

        // Fill: BUSY for exactly 16 cycles; requests are ignored meanwhile.
        RST = 1'b0;
        fill_wait("fill_cycles");
        check("fill_rd_cnt", 32'(RD_CNT), 32'd0);
        check("fill_wr_cnt", 32'(WR_CNT), 32'd0);
        check("fill_addr_err", 32'(ADDR_ERR), 32'd0);

        // Table-driven traffic
        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), 32'(ADDR_ERR), 32'd0);
        end
        check("tbl_rd_cnt", 32'(RD_CNT), 32'(m_rd));
        check("tbl_wr_cnt", 32'(WR_CNT), 32'(m_wr));
        step();
        check("idle_hold", DRDATA, 32'hFFFFFFFF);

        // Out-of-range handling and the error flag
        do_req(1'b0, 30'h400, 32'h0, 32'h0, "oor_rd");
        check("oor_rd_err", 32'(ADDR_ERR), 32'd1);
        check("oor_rd_cnt", 32'(RD_CNT), 32'(m_rd));
        step();
        check("err_sticky", 32'(ADDR_ERR), 32'd1);
        ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
        check("err_clr", 32'(ADDR_ERR), 32'd0);
        ERR_CLR = 1'b1;
        do_req(1'b1, 30'h3FFFFFFF, 32'h55, 32'h0, "oor_wr");
        ERR_CLR = 1'b0;
        check("set_wins", 32'(ADDR_ERR), 32'd1);
        check("oor_wr_cnt", 32'(WR_CNT), 32'(m_wr));
        do_req(1'b0, 30'd15, 32'h0, 32'hFFFFFFFF, "oor_wr_dropped");
        ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
        check("err_clr2", 32'(ADDR_ERR), 32'd0);

        // Saturating read counter
        for (int i = 0; i < 20; i++) do_req(1'b0, 30'd7, 32'h0, 32'h12345678, "sat_rd");
        check("rd_sat", 32'(RD_CNT), 32'(m_rd));
        check("rd_sat_const", 32'(RD_CNT), 32'hF);

        // Reset mid-operation, with a request in the reset cycle
        do_req(1'b1, 30'h400, 32'h1, 32'h12345678, "pre_rst_oor");
        check("pre_rst_err", 32'(ADDR_ERR), 32'd1);
        RST = 1'b1; DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd0; DWDATA = 32'hA5A5A5A5;
        step();
        RST = 1'b0; DREQ = 1'b0; DRW = 1'b0;
        m_rd = 0; m_wr = 0;
        check_reset_state("rst2");

        // Reset again in the middle of the fill; the full fill restarts.
        for (int i = 0; i < 5; i++) step();
        check("mid_fill_busy", 32'(BUSY), 32'd1);
        RST = 1'b1; step(); RST = 1'b0;
        fill_wait("refill_cycles");
        check("refill_rd_cnt", 32'(RD_CNT), 32'd0);
        check("refill_wr_cnt", 32'(WR_CNT), 32'd0);
        do_req(1'b0, 30'd7, 32'h0, 32'h0, "rezero_7");
        do_req(1'b0, 30'd15, 32'h0, 32'h0, "rezero_15");
        do_req(1'b0, 30'd0, 32'h0, 32'h0, "rezero_0");
        check("post_rst_rd_cnt", 32'(RD_CNT), 32'(m_rd));

`ifdef RISC_TOY_DMEM_PARITY_EN
        check("par_clean", 32'(PAR_ERR), 32'd0);
        PAR_INJ = 1'b1;
        do_req(1'b1, 30'd2, 32'h1, 32'h0, "par_inj_wr");
        PAR_INJ = 1'b0;
        check("par_no_err_on_wr", 32'(PAR_ERR), 32'd0);
        do_req(1'b0, 30'd2, 32'h0, 32'h1, "par_inj_rd");
        check("par_err_set", 32'(PAR_ERR), 32'd1);
        ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
        check("par_err_clr", 32'(PAR_ERR), 32'd0);
        do_req(1'b1, 30'd4, 32'h3, 32'h1, "par_ok_wr");
        do_req(1'b0, 30'd4, 32'h0, 32'h3, "par_ok_rd");
        check("par_ok", 32'(PAR_ERR), 32'd0);
        ERR_CLR = 1'b1;
        do_req(1'b0, 30'd2, 32'h0, 32'h1, "par_set_wins_rd");
        ERR_CLR = 1'b0;
        check("par_set_wins", 32'(PAR_ERR), 32'd1);
`endif

        if (sb_q.size() != 0) check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
